// File: rtl/pc_shot_initiator.sv
// Computer-side Battleship shooter: waits out a think delay, picks an unshot cell
// (random draws, then a linear scan), fires at it and waits for the board to record it.
module pc_shot_initiator #(
    parameter int unsigned ROWS         = 5,
    parameter int unsigned COLS         = 5,
    parameter logic [7:0]  SEED         = 8'hA5,
    parameter int unsigned THINK_CYCLES = 16,
    parameter int unsigned MAX_DRAWS    = 8,
    parameter int unsigned ACK_TIMEOUT  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     turn_start,
    input  logic [2*ROWS*COLS-1:0]   board,
    output logic [2:0]               shoot_row,
    output logic [2:0]               shoot_col,
    output logic                     fire_pc,
    output logic                     pc_mov,
    output logic                     hit,
    output logic                     no_target,
    output logic                     timeout,
    output logic                     busy
);

    localparam int unsigned BOARD_W = 2 * ROWS * COLS;
    localparam int unsigned IDX_W   = $clog2(BOARD_W);
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE, THINK, DRAW, SCAN, FIRE, WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        scan_row_q, scan_row_d, scan_col_q, scan_col_d;
    logic [2:0]        shoot_row_q, shoot_row_d, shoot_col_q, shoot_col_d;
    logic              hit_q, hit_d;
    logic              fire_q, fire_d, mov_q, mov_d, nt_q, nt_d, to_q, to_d;
    logic              busy_q, busy_d;

    logic [2:0]        cand_row, cand_col;
    logic [1:0]        cand_cell, scan_cell, tgt_cell;
    logic              cand_ok;

    // Two-bit cell at (r,c); callers guarantee r<ROWS, c<COLS before using the result.
    function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b,
                                           input logic [2:0] r, input logic [2:0] c);
        logic [IDX_W-1:0] pos;
        pos = IDX_W'((32'(r) * COLS + 32'(c)) * 2);
        return b[pos +: 2];
    endfunction

    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cand_row  = lfsr_q[2:0];
    assign cand_col  = lfsr_q[5:3];
    assign cand_cell = cell_at(board, cand_row, cand_col);
    assign scan_cell = cell_at(board, scan_row_q, scan_col_q);
    assign tgt_cell  = cell_at(board, shoot_row_q, shoot_col_q);
    assign cand_ok   = (32'(cand_row) < ROWS) && (32'(cand_col) < COLS) && !cand_cell[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            cnt_q       <= '0;
            scan_row_q  <= '0;
            scan_col_q  <= '0;
            shoot_row_q <= '0;
            shoot_col_q <= '0;
            hit_q       <= 1'b0;
            fire_q      <= 1'b0;
            mov_q       <= 1'b0;
            nt_q        <= 1'b0;
            to_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            scan_row_q  <= scan_row_d;
            scan_col_q  <= scan_col_d;
            shoot_row_q <= shoot_row_d;
            shoot_col_q <= shoot_col_d;
            hit_q       <= hit_d;
            fire_q      <= fire_d;
            mov_q       <= mov_d;
            nt_q        <= nt_d;
            to_q        <= to_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; pulses are registered so they appear in the cycle of the new state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        scan_row_d  = scan_row_q;
        scan_col_d  = scan_col_q;
        shoot_row_d = shoot_row_q;
        shoot_col_d = shoot_col_q;
        hit_d       = hit_q;
        mov_d       = 1'b0;
        nt_d        = 1'b0;
        to_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (turn_start) begin
                    state_d = THINK;
                    cnt_d   = '0;
                end
            end
            THINK: begin
                if (cnt_q == CNT_W'(THINK_CYCLES - 1)) begin
                    state_d = DRAW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    shoot_row_d = cand_row;
                    shoot_col_d = cand_col;
                    state_d     = FIRE;
                end else if (cnt_q == CNT_W'(MAX_DRAWS - 1)) begin
                    state_d    = SCAN;
                    cnt_d      = '0;
                    scan_row_d = '0;
                    scan_col_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCAN: begin
                if (!scan_cell[1]) begin
                    shoot_row_d = scan_row_q;
                    shoot_col_d = scan_col_q;
                    state_d     = FIRE;
                end else if (scan_row_q == 3'(ROWS - 1) && scan_col_q == 3'(COLS - 1)) begin
                    nt_d    = 1'b1;
                    state_d = IDLE;
                end else if (scan_col_q == 3'(COLS - 1)) begin
                    scan_col_d = '0;
                    scan_row_d = scan_row_q + 3'(1);
                end else begin
                    scan_col_d = scan_col_q + 3'(1);
                end
            end
            FIRE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (tgt_cell[1]) begin
                    hit_d   = tgt_cell[0];
                    mov_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        fire_d = (state_d == FIRE);
        busy_d = (state_d != IDLE);
    end

    assign shoot_row = shoot_row_q;
    assign shoot_col = shoot_col_q;
    assign fire_pc   = fire_q;
    assign pc_mov    = mov_q;
    assign hit       = hit_q;
    assign no_target = nt_q;
    assign timeout   = to_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pc_shot_initiator.sv
// Directed bench for pc_shot_initiator: think delay, hit/miss records, timeout,
// full board and reset in the middle of a turn.
module tb_pc_shot_initiator;

    logic        clock;
    logic        reset;
    logic        turn_start;
    logic [49:0] board;
    logic [2:0]  shoot_row;
    logic [2:0]  shoot_col;
    logic        fire_pc;
    logic        pc_mov;
    logic        hit;
    logic        no_target;
    logic        timeout;
    logic        busy;

    int n_tests, n_fail;
    int n_fire, n_mov, n_nt, n_to;
    int lat, a_lat, a_row, a_col;

    pc_shot_initiator dut (
        .clock      (clock),
        .reset      (reset),
        .turn_start (turn_start),
        .board      (board),
        .shoot_row  (shoot_row),
        .shoot_col  (shoot_col),
        .fire_pc    (fire_pc),
        .pc_mov     (pc_mov),
        .hit        (hit),
        .no_target  (no_target),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally the pulse outputs seen there.
    task automatic tick();
        @(negedge clock);
        if (fire_pc)   n_fire++;
        if (pc_mov)    n_mov++;
        if (no_target) n_nt++;
        if (timeout)   n_to++;
    endtask

    task automatic set_cell(input int r, input int c, input logic [1:0] v);
        board[6'(2 * (r * 5 + c)) +: 2] = v;
    endtask

    task automatic fill_board(input logic [1:0] v);
        for (int i = 0; i < 25; i++) board[6'(2 * i) +: 2] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_turn();
        n_fire = 0; n_mov = 0; n_nt = 0; n_to = 0;
        turn_start = 1'b1;
        tick();
        turn_start = 1'b0;
    endtask

    // Wait up to max_cyc cycles for a pulse: 0 fire_pc, 1 pc_mov, 2 no_target, 3 timeout.
    task automatic wait_evt(input int which, input int max_cyc, output int cycles);
        logic seen;
        cycles = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            case (which)
                0:       seen = fire_pc;
                1:       seen = pc_mov;
                2:       seen = no_target;
                default: seen = timeout;
            endcase
            if (seen) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        n_fire = 0; n_mov = 0; n_nt = 0; n_to = 0;
        reset = 1'b1; turn_start = 1'b0; board = '0;

        // Reset state, then think delay with an empty board; the bench records a hit.
        fill_board(2'b00);
        do_reset();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_row", int'(shoot_row), 0);
        check_eq("rst_col", int'(shoot_col), 0);
        check_eq("rst_hit", int'(hit), 0);
        check_eq("rst_pulses", int'({fire_pc, pc_mov, no_target, timeout}), 0);
        start_turn();
        wait_evt(0, 60, lat);
        check_eq("think_fire_seen", int'(lat > 0), 1);
        check_eq("think_min_delay", int'(lat >= 17), 1);
        check_eq("think_max_delay", int'(lat <= 51), 1);
        a_lat = lat; a_row = int'(shoot_row); a_col = int'(shoot_col);
        check_eq("think_row_range", int'(a_row < 5), 1);
        check_eq("think_col_range", int'(a_col < 5), 1);
        set_cell(a_row, a_col, 2'b11);
        tick();
        check_eq("think_fire_1cyc", int'(fire_pc), 0);
        wait_evt(1, 10, lat);
        check_eq("think_mov_lat", lat, 1);
        check_eq("think_hit", int'(hit), 1);
        tick();
        check_eq("think_mov_1cyc", int'(pc_mov), 0);
        check_eq("think_idle", int'(busy), 0);
        check_eq("think_one_fire", n_fire, 1);

        // Miss path: board records a miss in the same cycle as fire_pc.
        fill_board(2'b10);
        set_cell(0, 2, 2'b00);
        start_turn();
        wait_evt(0, 60, lat);
        check_eq("miss_fire_seen", int'(lat > 0), 1);
        check_eq("miss_row", int'(shoot_row), 0);
        check_eq("miss_col", int'(shoot_col), 2);
        set_cell(0, 2, 2'b10);
        wait_evt(1, 10, lat);
        check_eq("miss_mov_lat", lat, 2);
        check_eq("miss_hit", int'(hit), 0);
        tick();
        check_eq("miss_mov_1cyc", int'(pc_mov), 0);
        check_eq("miss_mov_count", n_mov, 1);

        // Single target at (4,3); recorded as a hit two cycles after fire_pc.
        fill_board(2'b10);
        set_cell(4, 3, 2'b01);
        start_turn();
        wait_evt(0, 60, lat);
        check_eq("tgt_fire_seen", int'(lat > 0), 1);
        check_eq("tgt_row", int'(shoot_row), 4);
        check_eq("tgt_col", int'(shoot_col), 3);
        tick();
        tick();
        set_cell(4, 3, 2'b11);
        wait_evt(1, 10, lat);
        check_eq("tgt_mov_lat", lat, 1);
        check_eq("tgt_hit", int'(hit), 1);
        tick();
        check_eq("tgt_mov_count", n_mov, 1);
        check_eq("tgt_fire_count", n_fire, 1);

        // Timeout: cell (1,1) is fired at but never recorded.
        fill_board(2'b10);
        set_cell(1, 1, 2'b00);
        start_turn();
        wait_evt(0, 60, lat);
        check_eq("to_fire_seen", int'(lat > 0), 1);
        check_eq("to_row", int'(shoot_row), 1);
        check_eq("to_col", int'(shoot_col), 1);
        wait_evt(3, 100, lat);
        check_eq("to_delay", lat, 65);
        check_eq("to_no_mov", n_mov, 0);
        check_eq("to_hit_kept", int'(hit), 1);
        check_eq("to_idle", int'(busy), 0);
        check_eq("to_row_held", int'(shoot_row), 1);

        // Full board: every cell already shot.
        fill_board(2'b10);
        set_cell(0, 0, 2'b11);
        set_cell(2, 3, 2'b11);
        set_cell(4, 4, 2'b11);
        start_turn();
        wait_evt(2, 60, lat);
        check_eq("full_nt_seen", int'(lat > 0), 1);
        check_eq("full_nt_bound", int'(lat <= 51), 1);
        repeat (3) tick();
        check_eq("full_nt_count", n_nt, 1);
        check_eq("full_no_fire", n_fire, 0);
        check_eq("full_no_mov", n_mov, 0);
        check_eq("full_idle", int'(busy), 0);

        // Reset two cycles after fire_pc, then the LFSR sequence must repeat.
        fill_board(2'b00);
        start_turn();
        wait_evt(0, 60, lat);
        check_eq("rw_fire_seen", int'(lat > 0), 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("rw_busy", int'(busy), 0);
        check_eq("rw_row", int'(shoot_row), 0);
        check_eq("rw_col", int'(shoot_col), 0);
        check_eq("rw_hit", int'(hit), 0);
        check_eq("rw_pulses", int'({fire_pc, pc_mov, no_target, timeout}), 0);
        tick();
        reset = 1'b0;
        fill_board(2'b00);
        start_turn();
        wait_evt(0, 60, lat);
        check_eq("rw_repeat_lat", lat, a_lat);
        check_eq("rw_repeat_row", int'(shoot_row), a_row);
        check_eq("rw_repeat_col", int'(shoot_col), a_col);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_shot_initiator.md
Name: pc_shot_initiator

Overview:
- Computer-side shooter for the Battleship game: when the game FSM grants the PC its turn, it picks an unshot cell on the player's 5x5 board and fires at it.
- Drives shoot_row/shoot_col/fire_pc into the player-board instance, then waits for the board to record the shot.
- Reports completion (pc_mov), the hit/miss result, and the no-target or timeout conditions back to the game FSM and display logic.

Parameters:
- ROWS, 5, board rows; row index 0..ROWS-1.
- COLS, 5, board columns; column index 0..COLS-1.
- SEED, 8'hA5, LFSR reset value; must be non-zero.
- THINK_CYCLES, 16, idle cycles between turn_start and the first candidate draw (>=1).
- MAX_DRAWS, 8, random draws tried before falling back to a linear scan.
- ACK_TIMEOUT, 64, cycles allowed in WAIT for the board to record the shot.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- turn_start  in  1  one-cycle pulse: PC turn begins.
- board  in  2*ROWS*COLS  player board. Cell idx = row*COLS+col occupies board[2*idx+1:2*idx]. Encoding: 00 water, 01 boat, 10 miss, 11 hit. A cell is "shot" when bit1 = 1.
- shoot_row  out  3  target row, held stable from FIRE until leaving WAIT.
- shoot_col  out  3  target column, same hold rule as shoot_row.
- fire_pc  out  1  one-cycle shot strobe to the board.
- pc_mov  out  1  one-cycle pulse: shot recorded, turn complete.
- hit  out  1  result of the last recorded shot (cell bit0); held until the next record or reset.
- no_target  out  1  one-cycle pulse: every cell is already shot.
- timeout  out  1  one-cycle pulse: board did not record the shot in time.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock domain, `clock`. Reset is synchronous and active-high on `reset`. It has priority over all other logic, including mid-turn.
- Reset values: state IDLE; lfsr=SEED; shoot_row=0; shoot_col=0; hit=0; all pulse outputs 0; all counters 0.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle regardless of state.
- IDLE: turn_start -> THINK with think counter cleared. turn_start seen in any other state is ignored.
- THINK: count THINK_CYCLES cycles -> DRAW, with the draw counter cleared.
- DRAW (1 candidate per cycle): candidate row = lfsr[2:0], col = lfsr[5:3].
  - Accept if row<ROWS, col<COLS and the cell is not shot: latch the coordinates -> FIRE.
  - Otherwise increment the draw counter. Once it reaches MAX_DRAWS -> SCAN starting at (0,0).
- SCAN: step one cell per cycle in row-major order (col increments; at COLS-1 wrap col to 0 and increment row).
  - First unshot cell: latch it -> FIRE.
  - Passing (ROWS-1,COLS-1) without a find: pulse no_target -> IDLE. pc_mov is not asserted.
- FIRE: fire_pc=1 for exactly this cycle -> WAIT, with the ack counter cleared.
- WAIT: each cycle, sample the latched cell of board.
  - Cell bit1=1: hit <= bit0, pc_mov pulses next cycle -> IDLE.
  - Counter reaches ACK_TIMEOUT with no record: pulse timeout -> IDLE. pc_mov is not asserted and hit is unchanged.
  - Board recording the cell in the same cycle as fire_pc is legal; it is detected on the first WAIT cycle.
- Latency: from turn_start, fire_pc asserts no earlier than THINK_CYCLES+1 cycles. The worst case is THINK_CYCLES+MAX_DRAWS+ROWS*COLS+2 cycles.
- Exclusivity: pulse outputs are mutually exclusive. At most one shot is fired per turn_start.
- shoot_row/shoot_col always hold the last fired coordinates when idle.
- Width rule: ROWS,COLS <= 8 (3-bit indices). A board wider than 2*ROWS*COLS is a misconnection, not a supported mode.

Test Plan:
- Think delay: reset, then turn_start at cycle 0, board all 00 -> fire_pc stays 0 through cycle THINK_CYCLES (16). fire_pc pulses exactly once, with shoot_row<5 and shoot_col<5.
- Single target: all cells 10 except (4,3)=01; turn_start; bench sets the cell to 11 two cycles after fire_pc -> shoot_row=4, shoot_col=3. pc_mov pulses once and hit=1.
- Miss path: all cells 10 except (0,2)=00; the bench writes 10 on fire_pc -> shoot_row=0, shoot_col=2, hit=0, pc_mov=1 for one cycle.
- Full board: all cells 10/11; turn_start -> no_target pulses once within 16+8+25+2 cycles. fire_pc and pc_mov never assert; busy returns to 0.
- Timeout: the bench never updates the board after fire_pc -> timeout pulses exactly ACK_TIMEOUT (64) cycles after WAIT entry. pc_mov=0, previous hit retained.
- Reset mid-WAIT: assert reset two cycles after fire_pc -> next cycle busy=0, shoot_row=shoot_col=0, hit=0, no pulses. A later turn_start repeats the same LFSR sequence as after the first reset.
